// File: rtl/vector_input_buffer.sv
// vector_input_buffer
// Small synchronous FIFO that captures N-lane vectors (plus an end-of-frame
// tag) from a source that cannot be stalled. Vectors that arrive while the
// buffer is full and nothing leaves are dropped, counted, and flagged.
// All status outputs come straight from registered state.
module vector_input_buffer #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int IB_DEPTH   = 4,   // power of two, >= 2
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         valid_in,
  input  logic [N*DATA_WIDTH-1:0]      vector_in,
  input  logic                         eof_in,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [N*DATA_WIDTH-1:0]      vector_out,
  output logic                         eof_out,
  output logic [$clog2(IB_DEPTH):0]    occupancy,
  output logic                         full,
  output logic                         empty,
  output logic                         overflow,
  output logic [CNT_WIDTH-1:0]         drop_count
);

  localparam int AW = $clog2(IB_DEPTH);
  localparam int VW = N * DATA_WIDTH;
  localparam int EW = VW + 1;                      // {eof, vector}
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(IB_DEPTH);

  // Storage and registered control state
  logic [EW-1:0]        r_mem [IB_DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [AW:0]          r_count;
  logic                 r_overflow;
  logic [CNT_WIDTH-1:0] r_drop_count;

  // Handshake decodes
  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_full  = (r_count == DEPTH_C);
  assign w_empty = (r_count == '0);

  // A pop is only possible when an entry is present, so a full buffer that
  // is also being popped has a free slot by the end of this edge.
  assign w_pop  = !w_empty && out_ready;
  assign w_push = enable && valid_in && (!w_full || w_pop);
  assign w_drop = enable && valid_in && w_full && !w_pop;

  // Capture the incoming entry at the write pointer.
  // NOTE: storage is deliberately left out of reset; the pointers and count
  // decide what is valid, so stale contents are never presented.
  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_mem[r_wr_ptr] <= {eof_in, vector_in};
    end
  end

  // Pointer, occupancy and drop bookkeeping; reset wins over any traffic.
  // NOTE: all state here uses non-blocking assignments so every register
  // sees the pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      // Power-of-two depth: the pointers wrap naturally at IB_DEPTH-1 -> 0.
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != '1) begin
          r_drop_count <= r_drop_count + 1'b1;
        end
      end
    end
  end

  // Head of the buffer is presented directly from storage at the read pointer.
  assign {eof_out, vector_out} = r_mem[r_rd_ptr];

  assign out_valid  = !w_empty;
  assign empty      = w_empty;
  assign full       = w_full;
  assign occupancy  = r_count;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_vector_input_buffer.sv
// Directed testbench for vector_input_buffer (N=8, DATA_WIDTH=32,
// IB_DEPTH=4). The drop counter is narrowed to 4 bits so saturation can be
// reached in a few dozen cycles.
module tb_vector_input_buffer;

  localparam int N   = 8;
  localparam int DW  = 32;
  localparam int D   = 4;
  localparam int CW  = 4;
  localparam int VW  = N * DW;

  logic              clk;
  logic              rst;
  logic              enable;
  logic              valid_in;
  logic [VW-1:0]     vector_in;
  logic              eof_in;
  logic              out_ready;
  logic              out_valid;
  logic [VW-1:0]     vector_out;
  logic              eof_out;
  logic [$clog2(D):0] occupancy;
  logic              full;
  logic              empty;
  logic              overflow;
  logic [CW-1:0]     drop_count;

  int n_total;
  int n_bad;

  vector_input_buffer #(
    .N(N), .DATA_WIDTH(DW), .IB_DEPTH(D), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .valid_in(valid_in),
    .vector_in(vector_in), .eof_in(eof_in), .out_ready(out_ready),
    .out_valid(out_valid), .vector_out(vector_out), .eof_out(eof_out),
    .occupancy(occupancy), .full(full), .empty(empty),
    .overflow(overflow), .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; outputs are then sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [VW:0] obs, input logic [VW:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] mkvec(input logic [31:0] base);
    logic [VW-1:0] v;
    for (int k = 0; k < N; k++) v[k*DW +: DW] = base + 32'(k);
    return v;
  endfunction

  task automatic push_vec(input logic [VW-1:0] v, input logic e);
    valid_in  = 1'b1;
    vector_in = v;
    eof_in    = e;
    tick();
    valid_in  = 1'b0;
  endtask

  logic [VW-1:0] vv [6];

  initial begin
    n_total = 0; n_bad = 0;
    rst = 1'b1; enable = 1'b0; valid_in = 1'b0; vector_in = '0;
    eof_in = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 6; i++) vv[i] = mkvec(32'h100 * (i + 1));

    // Reset state
    tick(); tick();
    rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_occ", occupancy, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drops", drop_count, 0);

    // Single vector, lanes 0..7, eof=1, visible one edge after push
    enable = 1'b1;
    push_vec(mkvec(0), 1'b1);
    check("single_valid", out_valid, 1);
    check("single_data", vector_out, mkvec(0));
    check("single_eof", eof_out, 1);
    check("single_occ", occupancy, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("single_empty", empty, 1);

    // Fill and overflow: six vectors into four slots
    for (int i = 0; i < 6; i++) begin
      push_vec(vv[i], i[0]);
      if (i == 3) check("fill_full4", full, 1);
      if (i == 2) check("fill_notfull3", full, 0);
    end
    check("fill_overflow", overflow, 1);
    check("fill_drops", drop_count, 2);
    check("fill_occ", occupancy, 4);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_v%0d", i), vector_out, vv[i]);
      check($sformatf("drain_eof%0d", i), eof_out, (i % 2 == 1) ? 1 : 0);
      tick();
    end
    out_ready = 1'b0;
    check("drain_empty", empty, 1);

    // Full with simultaneous pop: V4 accepted, no drop
    for (int i = 0; i < 4; i++) push_vec(vv[i], 1'b0);
    check("fp_full", full, 1);
    check("fp_head", vector_out, vv[0]);
    out_ready = 1'b1;
    push_vec(vv[4], 1'b1);
    out_ready = 1'b0;
    check("fp_drops", drop_count, 2);
    check("fp_occ", occupancy, 4);
    out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      check($sformatf("fp_order_v%0d", i), vector_out, vv[i]);
      tick();
    end
    out_ready = 1'b0;
    check("fp_empty", empty, 1);

    // Clean reset, then wrap-around streaming with out_ready=1
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst2_drops", drop_count, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      valid_in  = 1'b1;
      vector_in = mkvec(32'h1000 + 32'(i) * 8);
      eof_in    = (i == 19);
      tick();
      check($sformatf("st_valid%0d", i), out_valid, 1);
      check($sformatf("st_data%0d", i), vector_out, mkvec(32'h1000 + 32'(i) * 8));
      check($sformatf("st_occ%0d", i), occupancy, 1);
    end
    valid_in = 1'b0;
    check("st_last_eof", eof_out, 1);
    tick();
    check("st_empty", empty, 1);
    check("st_drops", drop_count, 0);
    out_ready = 1'b0;

    // Enable gating: three ignored vectors, then one accepted
    enable = 1'b0;
    for (int i = 0; i < 3; i++) push_vec(mkvec(32'hdead0000 + 32'(i) * 16), 1'b1);
    check("gate_empty", empty, 1);
    check("gate_drops", drop_count, 0);
    enable = 1'b1;
    push_vec(mkvec(32'h2000), 1'b0);
    check("gate_occ", occupancy, 1);
    check("gate_data", vector_out, mkvec(32'h2000));
    enable = 1'b0;
    out_ready = 1'b1;
    tick();
    check("gate_drain_empty", empty, 1);
    out_ready = 1'b0;
    enable = 1'b1;

    // Reset mid-operation: occupancy 3, drop_count 5
    for (int i = 0; i < 9; i++) push_vec(mkvec(32'h3000 + 32'(i) * 8), 1'b0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("pre_rst_occ", occupancy, 3);
    check("pre_rst_drops", drop_count, 5);
    rst = 1'b1;
    push_vec(mkvec(32'h4000), 1'b1);
    rst = 1'b0;
    check("mid_rst_occ", occupancy, 0);
    check("mid_rst_drops", drop_count, 0);
    check("mid_rst_overflow", overflow, 0);
    check("mid_rst_valid", out_valid, 0);
    push_vec(mkvec(32'h5000), 1'b0);
    check("post_rst_head", vector_out, mkvec(32'h5000));
    check("post_rst_occ", occupancy, 1);

    // Drop counter saturates at 2^CW-1
    for (int i = 0; i < 23; i++) push_vec(mkvec(32'h6000 + 32'(i) * 8), 1'b0);
    check("sat_drops", drop_count, 15);
    check("sat_overflow", overflow, 1);
    check("sat_head", vector_out, mkvec(32'h5000));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
